// File: rtl/dmem_pkg.sv
// Shared types and helpers for the load/store sequencer.
package dmem_pkg;

  localparam logic [1:0] ACC_BYTE = 2'b00;
  localparam logic [1:0] ACC_HALF = 2'b01;
  localparam logic [1:0] ACC_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_t;

  // True when the access cannot be issued: illegal mode or misaligned offset.
  function automatic logic misaligned(input logic [1:0] off, input logic [1:0] mode);
    case (mode)
      ACC_BYTE: return 1'b0;
      ACC_HALF: return off[0];
      ACC_WORD: return off != 2'b00;
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Execute-side request/response and memory-side bus of the LSU.
// slave: LSU view. master: the environment driving requests and modelling memory.
interface dmem_lsu_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_accessmode;
  logic              req_extendmode;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic [1:0]        rsp_accessmode;
  logic              rsp_extendmode;
  logic              rsp_err;

  modport slave (
    input  req_valid, req_write, req_accessmode, req_extendmode, req_addr, req_wdata,
    output req_ready,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output rsp_valid, rsp_rdata, rsp_accessmode, rsp_extendmode, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_write, req_accessmode, req_extendmode, req_addr, req_wdata,
    input  req_ready,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  rsp_valid, rsp_rdata, rsp_accessmode, rsp_extendmode, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: byte enables and replicated store data on the way out,
// shifted and zero-masked load data on the way back.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [1:0]  mode_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  // Lane selection per access size; sign extension is left to the consumer.
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = wdata_i;
    shifted = rdata_i >> {off_i, 3'b000};
    rdata_o = 32'h0;
    case (mode_i)
      ACC_BYTE: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {24'h0, shifted[7:0]};
      end
      ACC_HALF: begin
        be_o    = 4'b0011 << {off_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {16'h0, shifted[15:0]};
      end
      ACC_WORD: begin
        be_o    = 4'b1111;
        rdata_o = shifted;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Single-outstanding load/store sequencer between execute and word-wide data memory.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic     clk,
  input logic     rst,
  dmem_lsu_if.slave lsu_if
);

  lsu_state_t        state_q, state_d;
  logic [1:0]        off_q;
  logic              mem_req_q, mem_we_q;
  logic [3:0]        mem_be_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              rsp_valid_q, rsp_ext_q, rsp_err_q;
  logic [1:0]        rsp_mode_q;
  logic [31:0]       rsp_rdata_q;

  logic              accept, req_err;
  logic [1:0]        al_off, al_mode;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata, al_rdata;

  assign lsu_if.req_ready = (state_q == IDLE);
  assign accept  = lsu_if.req_valid && lsu_if.req_ready;
  assign req_err = misaligned(lsu_if.req_addr[1:0], lsu_if.req_accessmode);

  // Store-side lanes are only needed at accept (IDLE), load-side lanes only in
  // WAIT, so one aligner is shared by muxing its offset/mode source.
  assign al_off  = (state_q == IDLE) ? lsu_if.req_addr[1:0]    : off_q;
  assign al_mode = (state_q == IDLE) ? lsu_if.req_accessmode : rsp_mode_q;

  dmem_lane_align u_align (
    .off_i   (al_off),
    .mode_i  (al_mode),
    .wdata_i (lsu_if.req_wdata),
    .rdata_i (lsu_if.mem_rdata),
    .be_o    (al_be),
    .wdata_o (al_wdata),
    .rdata_o (al_rdata)
  );

  // Next-state: errors skip memory, stores skip WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept)            state_d = req_err ? RESP : REQ;
      REQ:  if (lsu_if.mem_gnt)    state_d = mem_we_q ? RESP : WAIT;
      WAIT: if (lsu_if.mem_rvalid) state_d = RESP;
      RESP: if (lsu_if.rsp_ready)  state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // State register and registered bus/response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      off_q       <= 2'b00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_ext_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_mode_q  <= 2'b00;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (accept) begin
          off_q       <= lsu_if.req_addr[1:0];
          rsp_mode_q  <= lsu_if.req_accessmode;
          rsp_ext_q   <= lsu_if.req_extendmode;
          rsp_err_q   <= req_err;
          rsp_rdata_q <= 32'h0;
          if (req_err) begin
            rsp_valid_q <= 1'b1;
          end else begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= lsu_if.req_write;
            mem_be_q    <= al_be;
            mem_wdata_q <= al_wdata;
            mem_addr_q  <= {lsu_if.req_addr[ADDR_W-1:2], 2'b00};
          end
        end
        REQ: if (lsu_if.mem_gnt) begin
          mem_req_q <= 1'b0;
          if (mem_we_q) rsp_valid_q <= 1'b1;
        end
        WAIT: if (lsu_if.mem_rvalid) begin
          rsp_rdata_q <= al_rdata;
          rsp_valid_q <= 1'b1;
        end
        RESP: if (lsu_if.rsp_ready) rsp_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign lsu_if.mem_req        = mem_req_q;
  assign lsu_if.mem_we         = mem_we_q;
  assign lsu_if.mem_be         = mem_be_q;
  assign lsu_if.mem_addr       = mem_addr_q;
  assign lsu_if.mem_wdata      = mem_wdata_q;
  assign lsu_if.rsp_valid      = rsp_valid_q;
  assign lsu_if.rsp_rdata      = rsp_rdata_q;
  assign lsu_if.rsp_accessmode = rsp_mode_q;
  assign lsu_if.rsp_extendmode = rsp_ext_q;
  assign lsu_if.rsp_err        = rsp_err_q;

endmodule
